// File: rtl/fir_mac_sequencer.sv
// -----------------------------------------------------------------------------
// fir_mac_sequencer
//   Time-multiplexed FIR filter controller. A single signed multiply-accumulate
//   is stepped across NTAPS coefficients for every accepted input sample, so
//   one sample is processed every NTAPS+2 cycles at best. The block owns the
//   sample delay line and a writable coefficient bank, and hands each result to
//   a downstream sink with a valid/ready handshake.
//
//   Samples, coefficients and results are signed WL-bit fixed point with WF
//   fractional bits. The result is the accumulator shifted right by WF with
//   floor rounding, then saturated to the WL-bit signed range.
//
// Ports
//   CLK        in   clock, rising edge
//   RST        in   asynchronous reset, active high
//   coef_we    in   coefficient write strobe (honoured only while idle)
//   coef_addr  in   tap index for the coefficient write
//   coef_data  in   coefficient value
//   in_valid   in   x_in is valid
//   in_ready   out  block can accept a sample (idle)
//   x_in       in   input sample
//   out_valid  out  y_out is valid
//   out_ready  in   sink accepts y_out
//   y_out      out  filtered sample, held stable while out_valid is high
//   busy       out  a sample is being processed or awaiting hand-off
// -----------------------------------------------------------------------------
module fir_mac_sequencer #(
  parameter int WL    = 8,
  parameter int WF    = 6,
  parameter int NTAPS = 3,
  localparam int AW   = $clog2(NTAPS)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          coef_we,
  input  logic [AW-1:0] coef_addr,
  input  logic [WL-1:0] coef_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WL-1:0] x_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WL-1:0] y_out,
  output logic          busy
);

  // Accumulator is wide enough to sum NTAPS full-precision products without
  // overflow.
  localparam int ACCW = 2 * WL + AW;

  localparam logic signed [ACCW-1:0] Y_MAX = ACCW'((1 << (WL - 1)) - 1);
  localparam logic signed [ACCW-1:0] Y_MIN = ~Y_MAX;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_DONE
  } state_e;

  // Power-on coefficient set; taps beyond the third start at zero.
  function automatic logic [WL-1:0] coef_rst(input int idx);
    logic [WL-1:0] val;
    val = '0;
    if (idx == 0) val = WL'(8'hEB);
    if (idx == 1) val = WL'(8'h33);
    if (idx == 2) val = WL'(8'h1A);
    return val;
  endfunction

  state_e                 state_q, state_d;
  logic [AW-1:0]          k_q, k_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic [WL-1:0]          y_q, y_d;

  logic signed [WL-1:0]   d_q [NTAPS];
  logic signed [WL-1:0]   h_q [NTAPS];

  logic                   shift_en;
  logic                   coef_wr_en;

  logic signed [2*WL-1:0] prod;
  logic signed [ACCW-1:0] acc_sum;
  logic signed [ACCW-1:0] acc_shr;
  logic [WL-1:0]          y_sat;

  // Shared datapath: the tap selected by k contributes this cycle.
  assign prod    = (2 * WL)'(d_q[k_q]) * (2 * WL)'(h_q[k_q]);
  assign acc_sum = acc_q + ACCW'(prod);
  assign acc_shr = acc_sum >>> WF;

  always_comb begin
    if (acc_shr > Y_MAX) begin
      y_sat = {1'b0, {(WL - 1){1'b1}}};
    end else if (acc_shr < Y_MIN) begin
      y_sat = {1'b1, {(WL - 1){1'b0}}};
    end else begin
      y_sat = acc_shr[WL-1:0];
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    acc_d      = acc_q;
    y_d        = y_q;
    shift_en   = 1'b0;
    coef_wr_en = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Out-of-range tap indices are silently dropped.
        coef_wr_en = coef_we && (int'(coef_addr) < NTAPS);
        if (in_valid) begin
          shift_en = 1'b1;
          acc_d    = '0;
          k_d      = '0;
          state_d  = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_sum;
        if (int'(k_q) == NTAPS - 1) begin
          // Result is taken from the final sum, including the last tap.
          y_d     = y_sat;
          state_d = S_DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      acc_q   <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
    end
  end

  // NOTE: the delay line and coefficient bank are small register arrays that
  // must come out of reset with defined contents (zero history, preset taps),
  // so they are reset like ordinary flops rather than mapped to a RAM.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NTAPS; i++) begin
        d_q[i] <= '0;
        h_q[i] <= coef_rst(i);
      end
    end else begin
      if (shift_en) begin
        d_q[0] <= x_in;
        for (int i = 1; i < NTAPS; i++) d_q[i] <= d_q[i-1];
      end
      if (coef_wr_en) h_q[coef_addr] <= coef_data;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign y_out     = y_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fir_mac_sequencer
//   Self-checking bench for fir_mac_sequencer at default parameters
//   (WL=8, WF=6, NTAPS=3): hand-derived vector table, directed corner-case
//   sequences, and randomized traffic against a behavioural FIR model.
// -----------------------------------------------------------------------------
module tb_fir_mac_sequencer;

  localparam int NTAPS = 3;

  logic       CLK;
  logic       RST;
  logic       coef_we;
  logic [1:0] coef_addr;
  logic [7:0] coef_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] x_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y_out;
  logic       busy;

  fir_mac_sequencer #(.WL(8), .WF(6), .NTAPS(NTAPS)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y_out     (y_out),
    .busy      (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: sample history and coefficient bank.
  logic signed [7:0] m_d [3];
  logic signed [7:0] m_h [3];

  function automatic logic [7:0] model_y();
    longint s;
    longint q;
    s = 0;
    for (int i = 0; i < 3; i++) s += longint'(m_d[i]) * longint'(m_h[i]);
    q = s / 64;
    if ((s % 64 != 0) && (s < 0)) q -= 1;  // floor toward -inf
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    return 8'(q);
  endfunction

  task automatic model_reset();
    m_h[0] = 8'hEB;
    m_h[1] = 8'h33;
    m_h[2] = 8'h1A;
    for (int i = 0; i < 3; i++) m_d[i] = '0;
  endtask

  task automatic model_push(input logic [7:0] x);
    m_d[2] = m_d[1];
    m_d[1] = m_d[0];
    m_d[0] = x;
  endtask

  task automatic do_reset();
    RST       = 1'b1;
    in_valid  = 1'b0;
    coef_we   = 1'b0;
    out_ready = 1'b0;
    x_in      = '0;
    coef_addr = '0;
    coef_data = '0;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic write_coef(input logic [1:0] a, input logic [7:0] v);
    coef_we   = 1'b1;
    coef_addr = a;
    coef_data = v;
    @(posedge CLK); #1;
    coef_we = 1'b0;
  endtask

  // Feeds one sample, optionally pulses a coefficient write during MAC,
  // holds off out_ready for 'hold' cycles, then completes the handshake.
  task automatic send_sample(input logic [7:0] x, input int hold, input logic bw,
                             input logic [1:0] ba, input logic [7:0] bd,
                             output logic [7:0] y);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    check("in_ready_before_accept", in_ready, 1);
    in_valid = 1'b1;
    x_in     = x;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    check("busy_after_accept", busy, 1);
    if (bw) begin
      coef_we   = 1'b1;
      coef_addr = ba;
      coef_data = bd;
    end
    n = 1;
    while (!out_valid && n < 30) begin
      @(posedge CLK); #1;
      coef_we = 1'b0;
      n++;
    end
    coef_we = 1'b0;
    check("latency_edges", n, NTAPS + 1);
    y = y_out;
    for (int i = 0; i < hold; i++) begin
      @(posedge CLK); #1;
      check("hold_out_valid", out_valid, 1);
      check("hold_y_stable", y_out, y);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;
    check("release_in_ready", in_ready, 1);
    check("release_out_valid", out_valid, 0);
  endtask

  typedef struct packed {
    logic [0:2][7:0] h;
    logic [0:2][7:0] x;
    logic [0:2][7:0] e;
  } vec_t;

  vec_t vecs [6];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [7:0] y;
    logic [7:0] x;
    logic [7:0] v;
    logic [1:0] a;

    // Hand-derived vectors: coefs, three samples after reset, three results.
    vecs[0] = '{h: {8'hEB, 8'h33, 8'h1A}, x: {8'h40, 8'h00, 8'h00}, e: {8'hEB, 8'h33, 8'h1A}};
    vecs[1] = '{h: {8'h7F, 8'h7F, 8'h7F}, x: {8'h7F, 8'h7F, 8'h7F}, e: {8'h7F, 8'h7F, 8'h7F}};
    vecs[2] = '{h: {8'h7F, 8'h7F, 8'h7F}, x: {8'h80, 8'h80, 8'h80}, e: {8'h80, 8'h80, 8'h80}};
    vecs[3] = '{h: {8'h01, 8'h00, 8'h00}, x: {8'hFF, 8'h00, 8'h00}, e: {8'hFF, 8'h00, 8'h00}};
    vecs[4] = '{h: {8'h40, 8'h40, 8'h40}, x: {8'h10, 8'h20, 8'hF0}, e: {8'h10, 8'h30, 8'h20}};
    vecs[5] = '{h: {8'h20, 8'h00, 8'h00}, x: {8'h03, 8'hFD, 8'h00}, e: {8'h01, 8'hFE, 8'h00}};

    // Reset state.
    RST       = 1'b1;
    in_valid  = 1'b0;
    coef_we   = 1'b0;
    out_ready = 1'b0;
    x_in      = '0;
    coef_addr = '0;
    coef_data = '0;
    #3;
    check("reset_in_ready", in_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_y_out", y_out, 0);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;

    // Impulse with power-on coefficients, no writes.
    for (int j = 0; j < 3; j++) begin
      send_sample(vecs[0].x[j], 0, 1'b0, 2'd0, 8'h00, y);
      check("impulse_default_coefs", y, vecs[0].e[j]);
    end

    // Vector table.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int j = 0; j < 3; j++) write_coef(2'(j), vecs[r].h[j]);
      for (int j = 0; j < 3; j++) begin
        send_sample(vecs[r].x[j], 0, 1'b0, 2'd0, 8'h00, y);
        check($sformatf("vec%0d_y%0d", r, j), y, vecs[r].e[j]);
      end
    end

    // Backpressure: 10 cycles of out_ready low in DONE.
    do_reset();
    send_sample(8'h40, 10, 1'b0, 2'd0, 8'h00, y);
    check("backpressure_y", y, 8'hEB);

    // Coefficient write while busy is dropped; same write in IDLE takes hold.
    do_reset();
    send_sample(8'h40, 0, 1'b1, 2'd1, 8'h10, y);
    check("busy_write_y0", y, 8'hEB);
    send_sample(8'h00, 0, 1'b0, 2'd0, 8'h00, y);
    check("busy_write_ignored", y, 8'h33);
    write_coef(2'd1, 8'h10);
    write_coef(2'd3, 8'h55);  // out-of-range index, no effect
    send_sample(8'h40, 0, 1'b0, 2'd0, 8'h00, y);
    check("idle_write_y0", y, 8'h05);
    send_sample(8'h00, 0, 1'b0, 2'd0, 8'h00, y);
    check("idle_write_new_h1", y, 8'h10);

    // Reset in the middle of MAC.
    do_reset();
    in_valid = 1'b1;
    x_in     = 8'h40;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
    #1;
    check("midreset_out_valid", out_valid, 0);
    check("midreset_busy", busy, 0);
    check("midreset_y_out", y_out, 0);
    @(posedge CLK); #1;
    RST = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK); #1;
      check("midreset_no_output", out_valid, 0);
    end
    for (int j = 0; j < 3; j++) begin
      send_sample(vecs[0].x[j], 0, 1'b0, 2'd0, 8'h00, y);
      check("midreset_impulse", y, vecs[0].e[j]);
    end

    // Randomized traffic against the behavioural model.
    do_reset();
    model_reset();
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        a = 2'($urandom_range(0, 3));
        v = 8'($urandom);
        write_coef(a, v);
        if (a < 2'd3) m_h[a] = v;
      end
      x = 8'($urandom);
      model_push(x);
      send_sample(x, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 8'($urandom), y);
      check("random_y", y, model_y());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
